// File: rtl/regfile_param_if.sv
// Register-file access bundle: one write port, a shared read enable for two read
// ports, the clear-sweep request and the busy flag.
interface regfile_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              init_req;
   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;
   logic              re;
   logic [ADDR_W-1:0] ra1;
   logic [ADDR_W-1:0] ra2;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic              busy;

   modport master (
      output init_req, we, wa, wd, re, ra1, ra2,
      input  rd1, rd2, busy
   );

   modport slave (
      input  init_req, we, wa, wd, re, ra1, ra2,
      output rd1, rd2, busy
   );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: registered dual read, optional zero register and
// write-to-read bypass, and a hardware clear sweep after reset or on request.
module regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic            clk,
   input logic            rst_n,
   regfile_param_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CW    = ADDR_W + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] rd1_q, rd1_d;
   logic [DATA_W-1:0] rd2_q, rd2_d;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we_s;
   logic [ADDR_W-1:0] mem_wa_s;
   logic [DATA_W-1:0] mem_wd_s;
   logic              wr_ok_s;

   // The zero register wins over bypass, which wins over the stored value.
   function automatic logic [DATA_W-1:0] read_mux(
      input logic [ADDR_W-1:0] ra,
      input logic [DATA_W-1:0] arr_val,
      input logic              we,
      input logic [ADDR_W-1:0] wa,
      input logic [DATA_W-1:0] wd
   );
      logic [DATA_W-1:0] val;
      if ((ZERO_REG != 0) && (ra == '0)) begin
         val = '0;
      end else if ((BYPASS != 0) && we && (wa == ra)) begin
         val = wd;
      end else begin
         val = arr_val;
      end
      return val;
   endfunction

   // Next-state, sweep counter, array write port and read-data selection.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      rd1_d    = rd1_q;
      rd2_d    = rd2_q;
      mem_we_s = 1'b0;
      mem_wa_s = bus.wa;
      mem_wd_s = bus.wd;
      wr_ok_s  = bus.we && !((ZERO_REG != 0) && (bus.wa == '0));

      case (state_q)
         ST_CLEAR: begin
            mem_we_s = 1'b1;
            mem_wa_s = cnt_q[ADDR_W-1:0];
            mem_wd_s = '0;
            if (bus.re) begin
               rd1_d = '0;
               rd2_d = '0;
            end else begin
               rd1_d = rd1_q;
               rd2_d = rd2_q;
            end
            if (cnt_q == CNT_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               busy_d  = 1'b0;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         ST_RUN: begin
            mem_we_s = wr_ok_s;
            if (bus.re) begin
               rd1_d = read_mux(bus.ra1, mem_q[bus.ra1], bus.we, bus.wa, bus.wd);
               rd2_d = read_mux(bus.ra2, mem_q[bus.ra2], bus.we, bus.wa, bus.wd);
            end else begin
               rd1_d = rd1_q;
               rd2_d = rd2_q;
            end
            // A write on the same edge lands first; the sweep clears it later.
            if (bus.init_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_RUN;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            busy_d  = 1'b1;
         end
      endcase
   end

   // Control and read-data registers; reset restarts the sweep from address 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
         rd1_q   <= '0;
         rd2_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
      end
   end

   // Storage array, deliberately without reset: the sweep establishes its contents.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[mem_wa_s] <= mem_wd_s;
      end
   end

   assign bus.rd1  = rd1_q;
   assign bus.rd2  = rd2_q;
   assign bus.busy = busy_q;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: a bypassing and a non-bypassing instance driven in
// lockstep and checked against an array-based model, directed then random.
module tb_regfile_param;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          init_req, we, re;
   logic [AW-1:0] wa, ra1, ra2;
   logic [DW-1:0] wd;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DW-1:0] m_mem [2][DEPTH];
   logic [DW-1:0] m_rd1 [2];
   logic [DW-1:0] m_rd2 [2];
   int            busy_left;

   regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
   regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

   assign bus_a.init_req = init_req;
   assign bus_a.we       = we;
   assign bus_a.wa       = wa;
   assign bus_a.wd       = wd;
   assign bus_a.re       = re;
   assign bus_a.ra1      = ra1;
   assign bus_a.ra2      = ra2;
   assign bus_b.init_req = init_req;
   assign bus_b.we       = we;
   assign bus_b.wa       = wa;
   assign bus_b.wd       = wd;
   assign bus_b.re       = re;
   assign bus_b.ra1      = ra1;
   assign bus_b.ra2      = ra2;

   regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_byp (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_nob (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // b=0 is the bypassing instance, b=1 the non-bypassing one.
   function automatic logic [DW-1:0] ref_read(input int b, input logic [AW-1:0] a);
      if (a == 0) return '0;
      if (b == 0 && we && wa == a) return wd;
      return m_mem[b][a];
   endfunction

   task automatic model_reset();
      busy_left = DEPTH;
      for (int b = 0; b < 2; b++) begin
         m_rd1[b] = '0;
         m_rd2[b] = '0;
         for (int i = 0; i < DEPTH; i++) m_mem[b][i] = '0;
      end
   endtask

   task automatic model_edge();
      if (busy_left > 0) begin
         for (int b = 0; b < 2; b++) begin
            if (re) begin
               m_rd1[b] = '0;
               m_rd2[b] = '0;
            end
         end
         busy_left--;
      end else begin
         for (int b = 0; b < 2; b++) begin
            if (re) begin
               m_rd1[b] = ref_read(b, ra1);
               m_rd2[b] = ref_read(b, ra2);
            end
            if (we && wa != 0) m_mem[b][wa] = wd;
         end
         // The whole array is zero once the sweep ends and unobservable before.
         if (init_req) begin
            busy_left = DEPTH;
            for (int b = 0; b < 2; b++)
               for (int i = 0; i < DEPTH; i++) m_mem[b][i] = '0;
         end
      end
   endtask

   task automatic check_outputs();
      check_eq("rd1_byp",  bus_a.rd1, m_rd1[0]);
      check_eq("rd2_byp",  bus_a.rd2, m_rd2[0]);
      check_eq("busy_byp", DW'(bus_a.busy), DW'(busy_left > 0));
      check_eq("rd1_nob",  bus_b.rd1, m_rd1[1]);
      check_eq("rd2_nob",  bus_b.rd2, m_rd2[1]);
      check_eq("busy_nob", DW'(bus_b.busy), DW'(busy_left > 0));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic set_idle();
      init_req = 1'b0;
      we       = 1'b0;
      re       = 1'b0;
      wa       = '0;
      wd       = '0;
      ra1      = '0;
      ra2      = '0;
   endtask

   // Counts edges until busy falls, with stray write/read attempts meanwhile.
   task automatic wait_sweep(input string tag);
      int n;
      n = 0;
      do begin
         init_req = 1'b0;
         we       = 1'($urandom_range(0, 1));
         wa       = ($urandom_range(0, 1) == 0) ? AW'(12) : AW'($urandom_range(0, DEPTH - 1));
         wd       = $urandom;
         re       = 1'($urandom_range(0, 1));
         ra1      = AW'($urandom_range(0, DEPTH - 1));
         ra2      = AW'($urandom_range(0, DEPTH - 1));
         tick();
         n++;
      end while (bus_a.busy && n < 100);
      check_eq(tag, DW'(n), DW'(DEPTH));
      set_idle();
   endtask

   initial begin
      rst_n = 1'b0;
      set_idle();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      #3 rst_n = 1'b1;
      wait_sweep("busy_len_rst");

      for (int a = 0; a < DEPTH; a++) begin
         re  = 1'b1;
         ra1 = AW'(a);
         ra2 = AW'(DEPTH - 1 - a);
         tick();
         check_eq("clr_rd1", bus_a.rd1, '0);
         check_eq("clr_rd2", bus_b.rd2, '0);
      end
      set_idle();

      we = 1'b1; wa = AW'(3); wd = 32'd4;
      tick();
      we = 1'b0; re = 1'b1; ra1 = AW'(3); ra2 = AW'(0);
      tick();
      check_eq("run_rd1", bus_a.rd1, 32'd4);
      check_eq("run_rd2", bus_a.rd2, 32'd0);
      we = 1'b1; re = 1'b0; wa = AW'(0); wd = 32'd8;
      tick();
      we = 1'b0; re = 1'b1; ra1 = AW'(0);
      tick();
      check_eq("zero_byp", bus_a.rd1, 32'd0);
      check_eq("zero_nob", bus_b.rd1, 32'd0);

      we = 1'b1; wa = AW'(7); wd = 32'hDEAD_BEEF; re = 1'b1; ra1 = AW'(7); ra2 = AW'(7);
      tick();
      check_eq("byp_rd1", bus_a.rd1, 32'hDEAD_BEEF);
      check_eq("byp_rd2", bus_a.rd2, 32'hDEAD_BEEF);
      check_eq("nob_old", bus_b.rd1, 32'd0);
      we = 1'b0;
      tick();
      check_eq("nob_new", bus_b.rd1, 32'hDEAD_BEEF);

      we = 1'b1; re = 1'b0; wa = AW'(5); wd = 32'd5;
      tick();
      we = 1'b0; re = 1'b1; ra1 = AW'(5);
      tick();
      check_eq("load5", bus_a.rd1, 32'd5);
      re = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ra1 = AW'($urandom_range(0, DEPTH - 1));
         tick();
         check_eq("hold_rd1", bus_a.rd1, 32'd5);
      end

      we = 1'b1; wa = AW'(12); wd = 32'd9;
      tick();
      we = 1'b0; re = 1'b1; ra1 = AW'(12);
      tick();
      check_eq("load9", bus_b.rd1, 32'd9);
      re = 1'b0; init_req = 1'b1;
      tick();
      check_eq("init_busy", DW'(bus_a.busy), DW'(1));
      wait_sweep("busy_len_init");
      re = 1'b1; ra1 = AW'(12); ra2 = AW'(12);
      tick();
      check_eq("init_clr_a", bus_a.rd1, 32'd0);
      check_eq("init_clr_b", bus_b.rd2, 32'd0);

      we = 1'b1; re = 1'b0; wa = AW'(20); wd = 32'h55;
      tick();
      we = 1'b0; re = 1'b1; ra1 = AW'(20); ra2 = AW'(20);
      tick();
      re = 1'b0; init_req = 1'b1;
      tick();
      init_req = 1'b0;
      repeat (9) tick();
      check_eq("pre_rst_rd1", bus_a.rd1, 32'h55);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("async_rd1",  bus_a.rd1, 32'd0);
      check_eq("async_rd2",  bus_b.rd2, 32'd0);
      check_eq("async_busy", DW'(bus_a.busy), DW'(1));
      #6 rst_n = 1'b1;
      wait_sweep("busy_len_rst2");

      for (int i = 0; i < 400; i++) begin
         init_req = ($urandom_range(0, 49) == 0);
         we       = 1'($urandom_range(0, 1));
         wa       = AW'($urandom_range(0, 7));
         wd       = $urandom;
         re       = 1'($urandom_range(0, 3) != 0);
         ra1      = AW'($urandom_range(0, 7));
         ra2      = AW'($urandom_range(0, 7));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
